// File: rtl/idu_pipe_buf.sv
// -----------------------------------------------------------------------------
// idu_pipe_buf
//
// Decode->execute pipeline buffer. Holds up to DEPTH decoded bundles in a
// circular queue so that EXU back-pressure does not immediately stall IDU.
// Acceptance is gated by the scoreboard hazard signal (stall), the whole
// queue is squashed on a pipeline flush, and a scoreboard allocate pulse is
// raised for every accepted bundle that writes a non-zero GPR.
//
// Parameters
//   DATA_W   width of one decoded bundle
//   DEPTH    number of queue entries (power of two, >= 1)
//   RST_VAL  value loaded into every entry on reset and on flush
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   flush      synchronous squash of all contents (redirect / trap)
//   stall      hazard hold: blocks acceptance, draining continues
//   in_valid   IDU offers a decoded bundle
//   in_ready   buffer accepts this cycle (combinational, depends on out_ready)
//   in_data    decoded bundle
//   in_regwr   bundle writes a GPR
//   in_rd      destination register index
//   out_valid  head entry valid toward EXU (registered)
//   out_ready  EXU takes the head entry this cycle
//   out_data   head entry
//   disp_en    scoreboard allocate pulse (combinational, accepting cycle)
//   disp_rd    destination register for the allocate pulse
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module idu_pipe_buf #(
   parameter int unsigned        DATA_W  = 64,
   parameter int unsigned        DEPTH   = 2,
   parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         stall,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_regwr,
   input  logic [4:0]                   in_rd,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         disp_en,
   output logic [4:0]                   disp_rd,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   // A single-entry buffer still needs a legal one-bit pointer; it is simply
   // never advanced away from zero.
   localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              valid_q,  valid_d;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic has_room;
   logic pop;
   logic accept;

   // Wrap modulo DEPTH explicitly so the pointer logic is also correct for
   // DEPTH=1, where the pointer must stay at zero.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
   endfunction

   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // condition, so no path leaves a signal unassigned and infers a latch.
      has_room = 1'b0;
      pop      = 1'b0;
      accept   = 1'b0;
      in_ready = 1'b0;
      disp_en  = 1'b0;

      pop = valid_q & out_ready;

      // When full, a pop in the same cycle frees the slot the new bundle will
      // occupy; this is the deliberate out_ready -> in_ready path.
      has_room = (count_q < CNT_FULL) | pop;
      in_ready = has_room & ~stall;

      // Reset and flush both drop any offered bundle, so no scoreboard entry
      // is allocated for something that never enters the queue.
      accept  = in_valid & in_ready & ~flush & ~rst;

      // x0 is hard-wired zero and never needs a scoreboard entry.
      disp_en = accept & in_regwr & (in_rd != 5'd0);
   end

   assign disp_rd = in_rd;

   // ------------------------------------------------------------------------
   // Next-state: pointers, occupancy, valid
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (accept) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         // Full/empty come only from the count: with DEPTH=1 or after a wrap
         // the pointers are equal in both the empty and the full case.
         unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      // out_valid is a flop, so a bundle is visible to EXU one cycle after
      // it is accepted and never combinationally from in_*.
      valid_d = (count_d != '0);
   end

   // ------------------------------------------------------------------------
   // Next-state: storage
   // ------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = flush ? RST_VAL : mem_q[i];
      end
      // Only the tail slot is written; the head and everything behind it are
      // untouched, which keeps out_data stable while EXU holds off.
      if (accept) begin
         mem_d[wr_ptr_q] = in_data;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of the others, independent of order.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   // NOTE: the entries are flops with a reset rather than a RAM macro, because
   // out_data must read RST_VAL after reset and flush; a reset on a real RAM
   // array would not map and would be left out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RST_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out_valid = valid_q;
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: tb/tb_idu_pipe_buf.sv
// -----------------------------------------------------------------------------
// tb_idu_pipe_buf
//
// Self-checking bench for idu_pipe_buf (DATA_W=64, DEPTH=2, RST_VAL=0).
// A queue-based reference model predicts every output each cycle; scenario
// tasks add directed checks for the documented corner cases, followed by a
// randomized run.
// -----------------------------------------------------------------------------
module tb_idu_pipe_buf;

   localparam int unsigned DW    = 64;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] RST_VAL = '0;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          stall;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_regwr;
   logic [4:0]    in_rd;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          disp_en;
   logic [4:0]    disp_rd;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: FIFO contents in order, plus whether every storage
   // entry is still at RST_VAL (true after reset/flush until the first accept).
   logic [DW-1:0] model_q [$];
   bit            fresh;

   idu_pipe_buf #(
      .DATA_W  (DW),
      .DEPTH   (DEPTH),
      .RST_VAL (RST_VAL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .stall     (stall),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_regwr  (in_regwr),
      .in_rd     (in_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .disp_en   (disp_en),
      .disp_rd   (disp_rd),
      .count     (count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock cycle: drive inputs (called at posedge+1), check every output
   // against the model mid-cycle, then advance the model across the edge.
   task automatic step(input bit iv, input logic [DW-1:0] d, input bit rw,
                       input logic [4:0] rd, input bit ordy, input bit st,
                       input bit fl);
      int            e_cnt;
      bit            e_valid, e_pop, e_rdy, e_acc, e_disp;
      in_valid  = iv;
      in_data   = d;
      in_regwr  = rw;
      in_rd     = rd;
      out_ready = ordy;
      stall     = st;
      flush     = fl;
      #2;
      e_cnt   = rst ? 0 : model_q.size();
      e_valid = (e_cnt != 0);
      e_pop   = e_valid && ordy;
      e_rdy   = ((e_cnt < DEPTH) || e_pop) && !st;
      e_acc   = iv && e_rdy && !fl && !rst;
      e_disp  = e_acc && rw && (rd != 5'd0);

      n_checks++;
      if (out_valid !== e_valid) begin
         n_fail++;
         $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, e_valid);
      end
      n_checks++;
      if (count !== CW'(e_cnt)) begin
         n_fail++;
         $display("FAIL count @%0t: got %0d expected %0d", $time, count, e_cnt);
      end
      n_checks++;
      if (in_ready !== e_rdy) begin
         n_fail++;
         $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, e_rdy);
      end
      n_checks++;
      if (disp_en !== e_disp) begin
         n_fail++;
         $display("FAIL disp_en @%0t: got %b expected %b", $time, disp_en, e_disp);
      end
      n_checks++;
      if (disp_rd !== rd) begin
         n_fail++;
         $display("FAIL disp_rd @%0t: got %0d expected %0d", $time, disp_rd, rd);
      end
      if (e_valid) begin
         n_checks++;
         if (out_data !== model_q[0]) begin
            n_fail++;
            $display("FAIL out_data @%0t: got %h expected %h", $time, out_data, model_q[0]);
         end
      end else if (fresh || rst) begin
         n_checks++;
         if (out_data !== RST_VAL) begin
            n_fail++;
            $display("FAIL out_data_rst @%0t: got %h expected %h", $time, out_data, RST_VAL);
         end
      end

      @(posedge clk);
      if (rst || fl) begin
         model_q.delete();
         fresh = 1'b1;
      end else begin
         if (e_pop) void'(model_q.pop_front());
         if (e_acc) begin
            model_q.push_back(d);
            fresh = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH + 2; i++) begin
         step(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      // Reset held with a bundle on offer: nothing may be taken or allocated.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 64'hDEAD_0000 + 64'(i), 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      end
      rst = 1'b0;
      n_checks++;
      if (out_data !== RST_VAL) begin
         n_fail++;
         $display("FAIL reset_out_data: got %h expected %h", out_data, RST_VAL);
      end
      idle();
   endtask

   task automatic test_fill_drain();
      step(1'b1, 64'hA, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hB, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(2) || out_data !== 64'hA) begin
         n_fail++;
         $display("FAIL fill: got count=%0d data=%h expected count=2 data=a", count, out_data);
      end
      // Full and not draining: an offered bundle must be refused.
      step(1'b1, 64'hFF, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (out_data !== 64'hB) begin
         n_fail++;
         $display("FAIL drain_order: got %h expected b", out_data);
      end
      step(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(0) || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: got count=%0d valid=%b expected 0 0", count, out_valid);
      end
   endtask

   task automatic test_full_pop();
      step(1'b1, 64'hA, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hB, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      // Full, EXU popping, IDU pushing C: in_ready must be 1 (checked in step).
      step(1'b1, 64'hC, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(2) || out_data !== 64'hB) begin
         n_fail++;
         $display("FAIL full_pop: got count=%0d data=%h expected count=2 data=b", count, out_data);
      end
      step(1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (out_data !== 64'hC) begin
         n_fail++;
         $display("FAIL full_pop_order: got %h expected c", out_data);
      end
      drain();
   endtask

   task automatic test_stall();
      step(1'b1, 64'h11, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      // Stalled offer while the head drains.
      step(1'b1, 64'h55, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (count !== CW'(0)) begin
         n_fail++;
         $display("FAIL stall_drain: got count=%0d expected 0", count);
      end
      step(1'b1, 64'h55, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
      // Released: exactly one dispatch pulse for rd=5.
      step(1'b1, 64'h55, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_x0();
      step(1'b1, 64'h0F0F, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(1) || out_data !== 64'h0F0F) begin
         n_fail++;
         $display("FAIL x0_store: got count=%0d data=%h expected 1 0f0f", count, out_data);
      end
      drain();
   endtask

   task automatic test_flush();
      step(1'b1, 64'h21, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h22, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h23, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (count !== CW'(0) || out_valid !== 1'b0 || out_data !== RST_VAL) begin
         n_fail++;
         $display("FAIL flush: got count=%0d valid=%b data=%h expected 0 0 0",
                  count, out_valid, out_data);
      end
      idle();
      drain();
   endtask

   task automatic test_mid_reset();
      step(1'b1, 64'h31, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h32, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || count !== CW'(0) || out_data !== RST_VAL) begin
         n_fail++;
         $display("FAIL mid_reset: got valid=%b count=%0d data=%h expected 0 0 0",
                  out_valid, count, out_data);
      end
      model_q.delete();
      fresh = 1'b1;
      #1;
      step(1'b1, 64'h33, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
      end
      drain();
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      stall     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_regwr  = 1'b0;
      in_rd     = 5'd0;
      out_ready = 1'b0;
      fresh     = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_fill_drain();
      test_full_pop();
      test_stall();
      test_x0();
      test_flush();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
